glb_fill_dispatcher: RTL
========================

Name: glb_fill_dispatcher

Overview:
- Read-side (rclk) controller of the DRAM-to-GLB interface FIFO.
- Pops words from the async FIFO read port and steers each word to one of NUM_CH GLB write ports (ifmap, filter, bias, ...).
- Per-transfer programmable base, length and stride; registered write strobes.
- Generalises the fixed 3-way demux and single address counter to N channels, with backpressure, strided addressing, abort and completion reporting.

Parameters:
- DATA_WIDTH, 64, FIFO/GLB word width
- NUM_CH, 3, number of GLB destination channels (>=2)
- ADDR_WIDTH, 20, GLB address width
- LEN_WIDTH, 16, transfer length counter width
- CH_W, $clog2(NUM_CH), channel select width (derived)

Ports:
- rclk  in  1  read-domain clock
- rreset  in  1  reset
- cfg_start  in  1  start pulse; config sampled same cycle
- cfg_ch  in  CH_W  destination channel
- cfg_base  in  ADDR_WIDTH  first GLB address
- cfg_stride  in  ADDR_WIDTH  address increment per word
- cfg_len  in  LEN_WIDTH  word count
- abort  in  1  terminate current transfer
- fifo_rempty  in  1  FIFO empty (already synchronised)
- fifo_rdata  in  DATA_WIDTH  FIFO head word (show-ahead)
- fifo_rinc  out  1  pop strobe
- glb_ready  in  NUM_CH  per-channel GLB can accept
- glb_wen  out  NUM_CH  one-hot write enable
- glb_waddr  out  ADDR_WIDTH  write address
- glb_wdata  out  DATA_WIDTH  write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: start while busy, or cfg_ch >= NUM_CH

Behaviour:
- rreset is asynchronous, active-high; rclk is the only clock. All outputs reset to 0; state resets to IDLE.
- States: IDLE, XFER, FLUSH.
- IDLE:
  - cfg_start with valid cfg_ch latches ch/base/stride/len and clears count; next state is XFER.
  - If cfg_len==0, go straight to FLUSH instead (done pulse, no writes).
- XFER:
  - fifo_rinc = !fifo_rempty & glb_ready[ch] (combinational, 0 in all other states).
  - On each pop, next cycle: glb_wen[ch]=1, glb_wdata=popped word, glb_waddr=cur_addr. Latency is 1 cycle from pop to write.
  - After each pop: cur_addr <= cur_addr + stride, modulo 2^ADDR_WIDTH (wraps, no error); count <= count+1.
  - Pop with count==len-1 transitions to FLUSH.
- FLUSH: lasts 1 cycle; the last write strobe is visible here; done=1; return to IDLE. busy=1 in XFER and FLUSH.
- Non-popping cycles: glb_wen=0; waddr/wdata hold their last value.
- Backpressure: glb_ready[ch] low stalls popping; other channels' ready bits are ignored.
- abort:
  - In XFER: no pop that cycle; go to FLUSH; done still pulses. A write already registered completes.
  - abort in IDLE is ignored.
- cfg_start while busy: ignored, err set.
- cfg_start with cfg_ch>=NUM_CH: ignored, err set.
- err clears only on rreset.
- Reset mid-transfer: immediate IDLE, strobes drop asynchronously, no done.

Decomposition:
- Package glb_if_pkg: state enum (IDLE/XFER/FLUSH), default widths, channel index constants (CH_IFMAP=0, CH_FILTER=1, CH_BIAS=2).
- One sub-module, glb_addr_gen: base/stride accumulator with load/step, reusable by the GLB-to-DRAM path.

Test Plan:
- Basic fill: ch=0, base=0x100, stride=1, len=4, FIFO holds A..D, ready=1 -> glb_wen[0] on 4 consecutive cycles at 0x100..0x103, data A..D; done pulses the cycle after the last pop; busy low after.
- Stride and wrap: ADDR_WIDTH=20, base=0xFFFFE, stride=2, len=3, ch=2 -> addresses 0xFFFFE, 0x00000, 0x00002 on glb_wen[2] only.
- Backpressure and empty: ch=1, len=3, toggle glb_ready[1] and fifo_rempty each cycle -> pops only when both permit; exactly 3 writes; no write on stall cycles; glb_ready[0] ignored.
- Zero length and abort: len=0 -> done after 1 cycle, no fifo_rinc. len=8 with abort after 2 pops -> exactly 2 writes, then done, IDLE.
- Errors: cfg_start during XFER -> err=1, transfer unaffected. cfg_ch=3 with NUM_CH=3 -> err=1, stays IDLE.
- Async reset mid-XFER: assert rreset between clocks -> glb_wen, fifo_rinc, busy go 0 immediately; no done; new transfer works after release.

Source files
------------

// File: rtl/glb_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glb_if_pkg
// Purpose  : Shared widths, channel indices and FSM encoding for the GLB
//            fill/drain interface controllers.
// Revision : 1.0
// ============================================================================
package glb_if_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_CH     = 3;
    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_LEN_WIDTH  = 16;

    localparam int CH_IFMAP  = 0;
    localparam int CH_FILTER = 1;
    localparam int CH_BIAS   = 2;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage
`default_nettype wire

// File: rtl/glb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : glb_addr_gen
// Purpose  : Base/stride address accumulator; load captures base and stride,
//            step advances by stride with natural modulo-2^ADDR_WIDTH wrap.
// Revision : 1.0
// ============================================================================
module glb_addr_gen
    import glb_if_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rreset,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_stride;

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            r_addr   <= '0;
            r_stride <= '0;
        end else if (i_load) begin
            r_addr   <= i_base;
            r_stride <= i_stride;
        end else if (i_step) begin
            r_addr   <= r_addr + r_stride;
        end
    end

    assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/glb_fill_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : glb_fill_dispatcher
// Purpose  : Read-side controller of the DRAM-to-GLB FIFO; pops words and
//            steers them to one of NUM_CH GLB write ports with strided addressing.
// Revision : 1.0
// ============================================================================
module glb_fill_dispatcher
    import glb_if_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                  rclk,
    input  logic                  rreset,
    input  logic                  cfg_start,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  abort,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    input  logic [NUM_CH-1:0]     glb_ready,
    output logic [NUM_CH-1:0]     glb_wen,
    output logic [ADDR_WIDTH-1:0] glb_waddr,
    output logic [DATA_WIDTH-1:0] glb_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [CH_W:0] C_NUM_CH = NUM_CH[CH_W:0];

    state_t                r_state;
    logic [CH_W-1:0]       r_ch;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_count;
    logic [NUM_CH-1:0]     r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;

    logic                  w_ch_ok;
    logic                  w_start_ok;
    logic                  w_pop;
    logic                  w_last;
    logic [NUM_CH-1:0]     w_onehot;
    logic [ADDR_WIDTH-1:0] w_cur_addr;

    assign w_ch_ok    = {1'b0, cfg_ch} < C_NUM_CH;
    assign w_start_ok = cfg_start && w_ch_ok && (r_state == ST_IDLE);
    // abort suppresses the pop in the same cycle it is seen
    assign w_pop      = (r_state == ST_XFER) && !abort && !fifo_rempty && glb_ready[r_ch];
    assign w_last     = (r_count == r_len - LEN_WIDTH'(1));
    assign w_onehot   = {{(NUM_CH-1){1'b0}}, 1'b1} << r_ch;

    glb_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .rclk     (rclk),
        .rreset   (rreset),
        .i_load   (w_start_ok),
        .i_base   (cfg_base),
        .i_stride (cfg_stride),
        .i_step   (w_pop),
        .o_addr   (w_cur_addr)
    );

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_wen   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wen <= '0;
            if (cfg_start && !w_start_ok) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_ch    <= cfg_ch;
                        r_len   <= cfg_len;
                        r_count <= '0;
                        r_state <= (cfg_len == '0) ? ST_FLUSH : ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (abort) begin
                        r_state <= ST_FLUSH;
                    end else if (w_pop) begin
                        r_wen   <= w_onehot;
                        r_waddr <= w_cur_addr;
                        r_wdata <= fifo_rdata;
                        r_count <= r_count + LEN_WIDTH'(1);
                        if (w_last) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_rinc = w_pop;
    assign glb_wen   = r_wen;
    assign glb_waddr = r_waddr;
    assign glb_wdata = r_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FLUSH);
    assign err       = r_err;

endmodule
`default_nettype wire
